wsg_audio_out: RTL

- Downstream of the 8-channel wave sound generator; consumes its 8-bit unsigned mix output.
- Converts that output to signed 16-bit PCM and removes DC with a one-pole high-pass filter.
- Serializes the result as mono-duplicated stereo I2S for the platform audio DAC.
- Runs on the same 24 MHz-class system clock as the generator.

---
 rtl/wsg_audio_out.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wsg_audio_out.sv
// Audio back end for the wave sound generator: 8-bit unsigned mix -> signed PCM,
// one-pole DC blocker, and mono-duplicated stereo I2S serializer.
module wsg_audio_out #(
  parameter int SCLK_DIV = 8,
  parameter int DCB_K    = 8,
  parameter bit DCB_EN   = 1'b1
) (
  input  logic        CLK24M,
  input  logic        RESET_N,
  input  logic [7:0]  SIN,
  input  logic        MUTE,
  output logic        AUDIO_MCLK,
  output logic        AUDIO_SCLK,
  output logic        AUDIO_LRCK,
  output logic        AUDIO_DAC,
  output logic [15:0] SAMPLE_OUT,
  output logic        SAMPLE_STB
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_DIFF  = 3'd2,
    ST_ACC   = 3'd3,
    ST_SAT   = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  state_t state_r, state_nxt_s;

  logic [DIV_W-1:0]    div_r;
  logic                sclk_r, mclk_r, lrck_r, dac_r, first_r;
  logic [4:0]          slot_r;
  logic [31:0]         shreg_r, frame_r;
  logic [7:0]          sync1_r, sync2_r, x_in_r;
  logic signed [15:0]  x_r, x_prev_r, y_state_r, sample_out_r, y_sat_s;
  logic signed [19:0]  d_r, a_r, y_ext_s;
  logic                stb_r;
  logic                sclk_fall_s, start_s;
  logic [4:0]          slot_nxt_s;

  assign sclk_fall_s = (div_r == DIV_LAST) && sclk_r;
  assign slot_nxt_s  = first_r ? 5'd0 : (slot_r + 5'd1);
  assign start_s     = sclk_fall_s && (slot_nxt_s == 5'd16);
  assign y_ext_s     = {{4{y_state_r[15]}}, y_state_r};

  // Clock dividers, slot counter and I2S shifter
  always_ff @(posedge CLK24M) begin
    if (!RESET_N) begin
      div_r   <= '0;
      sclk_r  <= 1'b0;
      mclk_r  <= 1'b0;
      lrck_r  <= 1'b0;
      dac_r   <= 1'b0;
      first_r <= 1'b1;
      slot_r  <= 5'd0;
      shreg_r <= 32'd0;
    end else begin
      mclk_r <= ~mclk_r;
      if (div_r == DIV_LAST) begin
        div_r  <= '0;
        sclk_r <= ~sclk_r;
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
      if (sclk_fall_s) begin
        slot_r  <= slot_nxt_s;
        first_r <= 1'b0;
        lrck_r  <= slot_nxt_s[4];
        // slot 1 starts a new word; slot 0 still carries the last word's LSB
        if (slot_nxt_s == 5'd1) begin
          dac_r   <= frame_r[31];
          shreg_r <= {frame_r[30:0], 1'b0};
        end else begin
          dac_r   <= shreg_r[31];
          shreg_r <= {shreg_r[30:0], 1'b0};
        end
      end
    end
  end

  // Two-flop synchronizer for the generator mix
  always_ff @(posedge CLK24M) begin
    if (!RESET_N) begin
      sync1_r <= 8'd0;
      sync2_r <= 8'd0;
    end else begin
      sync1_r <= SIN;
      sync2_r <= sync1_r;
    end
  end

  // Processing FSM state register
  always_ff @(posedge CLK24M) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Processing FSM next state: one step per clock once triggered
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = start_s ? ST_LATCH : ST_IDLE;
      ST_LATCH: state_nxt_s = ST_DIFF;
      ST_DIFF:  state_nxt_s = ST_ACC;
      ST_ACC:   state_nxt_s = ST_SAT;
      ST_SAT:   state_nxt_s = ST_OUT;
      ST_OUT:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output clamp; saturated value also feeds back so the filter cannot wind up
  always_comb begin
    y_sat_s = x_r;
    if (DCB_EN) begin
      if (a_r > 20'sd32767) begin
        y_sat_s = 16'sh7FFF;
      end else if (a_r < -20'sd32768) begin
        y_sat_s = 16'sh8000;
      end else begin
        y_sat_s = a_r[15:0];
      end
    end else begin
      y_sat_s = x_r;
    end
  end

  // DC blocker datapath and sample/strobe outputs
  always_ff @(posedge CLK24M) begin
    if (!RESET_N) begin
      x_in_r       <= 8'd0;
      x_r          <= 16'sd0;
      x_prev_r     <= 16'sd0;
      y_state_r    <= 16'sd0;
      d_r          <= 20'sd0;
      a_r          <= 20'sd0;
      sample_out_r <= 16'sd0;
      stb_r        <= 1'b0;
      frame_r      <= 32'd0;
    end else begin
      stb_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            x_in_r <= MUTE ? 8'h80 : sync2_r;
          end else begin
            x_in_r <= x_in_r;
          end
        end
        ST_LATCH: x_r <= {x_in_r ^ 8'h80, 8'h00};
        ST_DIFF:  d_r <= {{4{x_r[15]}}, x_r} - {{4{x_prev_r[15]}}, x_prev_r};
        ST_ACC:   a_r <= d_r + y_ext_s - (y_ext_s >>> DCB_K);
        ST_SAT: begin
          y_state_r    <= y_sat_s;
          x_prev_r     <= x_r;
          sample_out_r <= y_sat_s;
          stb_r        <= 1'b1;
        end
        ST_OUT:   frame_r <= {sample_out_r, sample_out_r};
        default:  frame_r <= frame_r;
      endcase
    end
  end

  assign AUDIO_MCLK = mclk_r;
  assign AUDIO_SCLK = sclk_r;
  assign AUDIO_LRCK = lrck_r;
  assign AUDIO_DAC  = dac_r;
  assign SAMPLE_OUT = sample_out_r;
  assign SAMPLE_STB = stb_r;

endmodule
